// File: rtl/sdram_cmd_sequencer.sv
// SDRAM command sequencer: power-up init, auto-refresh scheduling, single-beat read/write with auto-precharge.
// Latency: ACT one cycle after accept, READA/WRITA T_RCD after ACT, rd_valid CAS_LAT+1 after READA.
// Backpressure: req_ready is high only in IDLE after init with no refresh pending; a held request waits, never drops.
//
// Ports:
//   clk, rst_n                   - clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready          - request handshake; req_we, req_addr {bank,row,col}, req_be, req_wdata
//   command, mrs                 - registered SDRAM command code, constant mode word
//   addr_out, be_out             - address / byte mask latched at accept
//   dq_in, dq_out, dq_oe         - data bus; dq_oe only during the WRITA cycle
//   rd_data, rd_valid            - read return, one-cycle pulse
//   init_done                    - initialisation finished, sticky until reset
module sdram_cmd_sequencer #(
    parameter int          INIT_WAIT    = 100,
    parameter int          T_RP         = 2,
    parameter int          T_RFC        = 7,
    parameter int          T_RCD        = 2,
    parameter int          CAS_LAT      = 2,
    parameter int          T_WR         = 2,
    parameter int          REF_INTERVAL = 780,
    parameter logic [11:0] MRS_VALUE    = 12'h020
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [21:0] req_addr,
    input  logic [1:0]  req_be,
    input  logic [15:0] req_wdata,
    output logic [3:0]  command,
    output logic [11:0] mrs,
    output logic [21:0] addr_out,
    output logic [1:0]  be_out,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        init_done
);

    localparam logic [3:0] CMD_DESL  = 4'b0000;
    localparam logic [3:0] CMD_NOP   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0010;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READA = 4'b0101;
    localparam logic [3:0] CMD_WRITA = 4'b0111;
    localparam logic [3:0] CMD_PALL  = 4'b1001;
    localparam logic [3:0] CMD_REF   = 4'b1011;

    // One shared wait counter sized for the longest load it ever receives.
    localparam int MAX_A   = (INIT_WAIT > REF_INTERVAL) ? INIT_WAIT : REF_INTERVAL;
    localparam int MAX_B   = (T_RFC > T_WR + T_RP) ? T_RFC : (T_WR + T_RP);
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int RCW     = $clog2(REF_INTERVAL + 1);

    // Loads are "number of NOP cycles still to show before the next step".
    // Init steps issue the next command straight off the counter, so they load the
    // full gap. Steps that return to IDLE spend one NOP cycle in IDLE before the
    // next command can go out, so their loads are one (or two, via RW) shorter.
    localparam logic [CW-1:0]  LD_INIT   = CW'(INIT_WAIT);
    localparam logic [CW-1:0]  LD_RP     = CW'(T_RP);
    localparam logic [CW-1:0]  LD_RFC    = CW'(T_RFC);
    localparam logic [CW-1:0]  LD_MRS    = CW'(2);
    localparam logic [CW-1:0]  LD_REF    = CW'(T_RFC - 1);
    localparam logic [CW-1:0]  LD_RCD    = CW'(T_RCD - 1);
    localparam logic [CW-1:0]  LD_CAS    = CW'(CAS_LAT - 1);
    localparam logic [CW-1:0]  LD_WRREC  = CW'(T_WR + T_RP - 2);
    localparam logic [RCW-1:0] REF_RELOAD = RCW'(REF_INTERVAL - 1);

    typedef enum logic [3:0] {
        S_INIT_WAIT,
        S_INIT_PALL,
        S_INIT_REF1,
        S_INIT_REF2,
        S_INIT_MRS,
        S_IDLE,
        S_REFRESH,
        S_ACTIVATE,
        S_RW,
        S_READ_WAIT,
        S_WRITE_WAIT
    } state_t;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [3:0]       cmd_nxt;
    logic             oe_nxt;
    logic             rdv_nxt;
    logic             latch;
    logic             capture;
    logic             done_set;
    logic             ref_issue;
    logic             we_q;
    logic [15:0]      wdata_q;
    logic [RCW-1:0]   ref_cnt;
    logic             ref_pending;

    assign mrs       = MRS_VALUE;
    assign req_ready = (state == S_IDLE) && init_done && !ref_pending;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt != '0) ? cnt - CW'(1) : cnt;
        cmd_nxt   = CMD_NOP;
        oe_nxt    = 1'b0;
        rdv_nxt   = 1'b0;
        latch     = 1'b0;
        capture   = 1'b0;
        done_set  = 1'b0;
        ref_issue = 1'b0;
        case (state)
            S_INIT_WAIT: if (cnt == '0) begin
                cmd_nxt   = CMD_PALL;
                state_nxt = S_INIT_PALL;
                cnt_nxt   = LD_RP;
            end
            S_INIT_PALL: if (cnt == '0) begin
                cmd_nxt   = CMD_REF;
                state_nxt = S_INIT_REF1;
                cnt_nxt   = LD_RFC;
            end
            S_INIT_REF1: if (cnt == '0) begin
                cmd_nxt   = CMD_REF;
                state_nxt = S_INIT_REF2;
                cnt_nxt   = LD_RFC;
            end
            S_INIT_REF2: if (cnt == '0) begin
                cmd_nxt   = CMD_MRS;
                state_nxt = S_INIT_MRS;
                cnt_nxt   = LD_MRS;
            end
            S_INIT_MRS: if (cnt == '0) begin
                state_nxt = S_IDLE;
                done_set  = 1'b1;
            end
            S_IDLE: begin
                // Refresh wins over a waiting request; req_ready is already low.
                if (ref_pending) begin
                    cmd_nxt   = CMD_REF;
                    state_nxt = S_REFRESH;
                    cnt_nxt   = LD_REF;
                    ref_issue = 1'b1;
                end else if (req_valid && req_ready) begin
                    cmd_nxt   = CMD_ACT;
                    state_nxt = S_ACTIVATE;
                    cnt_nxt   = LD_RCD;
                    latch     = 1'b1;
                end
            end
            S_REFRESH: if (cnt == '0) begin
                state_nxt = S_IDLE;
            end
            S_ACTIVATE: if (cnt == '0) begin
                cmd_nxt   = we_q ? CMD_WRITA : CMD_READA;
                oe_nxt    = we_q;
                state_nxt = S_RW;
            end
            S_RW: begin
                if (we_q) begin
                    state_nxt = S_WRITE_WAIT;
                    cnt_nxt   = LD_WRREC;
                end else begin
                    state_nxt = S_READ_WAIT;
                    cnt_nxt   = LD_CAS;
                end
            end
            S_READ_WAIT: if (cnt == '0) begin
                capture   = 1'b1;
                rdv_nxt   = 1'b1;
                state_nxt = S_IDLE;
            end
            S_WRITE_WAIT: if (cnt == '0) begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_INIT_WAIT;
                cnt_nxt   = LD_INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_INIT_WAIT;
            cnt         <= LD_INIT;
            command     <= CMD_DESL;
            addr_out    <= '0;
            be_out      <= 2'b11;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            dq_out      <= '0;
            dq_oe       <= 1'b0;
            rd_data     <= '0;
            rd_valid    <= 1'b0;
            init_done   <= 1'b0;
            ref_cnt     <= REF_RELOAD;
            ref_pending <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            command  <= cmd_nxt;
            dq_oe    <= oe_nxt;
            dq_out   <= oe_nxt ? wdata_q : 16'h0000;
            rd_valid <= rdv_nxt;
            if (latch) begin
                addr_out <= req_addr;
                be_out   <= req_be;
                we_q     <= req_we;
                wdata_q  <= req_wdata;
            end
            if (capture) begin
                rd_data <= dq_in;
            end
            if (done_set) begin
                init_done <= 1'b1;
            end
            // Refresh timer: starts when init completes. Expiry on the same
            // cycle as a REF keeps the pending flag set for the next round.
            if (done_set) begin
                ref_cnt <= REF_RELOAD;
            end else if (init_done) begin
                if (ref_cnt == '0) begin
                    ref_cnt     <= REF_RELOAD;
                    ref_pending <= 1'b1;
                end else begin
                    ref_cnt <= ref_cnt - RCW'(1);
                    if (ref_issue) begin
                        ref_pending <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// Bench for sdram_cmd_sequencer: directed init / read / write / refresh / reset scenarios.
// Expected command, read-return and write-drive events are queued with hand-derived cycle numbers.
// A negedge monitor pops and compares whenever the DUT shows a non-NOP command, rd_valid or dq_oe.
module tb_sdram_cmd_sequencer;

    localparam logic [3:0] C_DESL  = 4'b0000;
    localparam logic [3:0] C_NOP   = 4'b0001;
    localparam logic [3:0] C_MRS   = 4'b0010;
    localparam logic [3:0] C_ACT   = 4'b0011;
    localparam logic [3:0] C_READA = 4'b0101;
    localparam logic [3:0] C_WRITA = 4'b0111;
    localparam logic [3:0] C_PALL  = 4'b1001;
    localparam logic [3:0] C_REF   = 4'b1011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [21:0] req_addr = '0;
    logic [1:0]  req_be = '0;
    logic [15:0] req_wdata = '0;
    logic [3:0]  command;
    logic [11:0] mrs;
    logic [21:0] addr_out;
    logic [1:0]  be_out;
    logic [15:0] dq_in = '0;
    logic [15:0] dq_out;
    logic        dq_oe;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        init_done;

    sdram_cmd_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .command   (command),
        .mrs       (mrs),
        .addr_out  (addr_out),
        .be_out    (be_out),
        .dq_in     (dq_in),
        .dq_out    (dq_out),
        .dq_oe     (dq_oe),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int          cyc;
        logic [3:0]  cmd;
        logic [21:0] addr;
        logic [1:0]  be;
        bit          chk;
    } cmd_ev_t;

    typedef struct {
        int          cyc;
        logic [15:0] d;
    } rd_ev_t;

    typedef struct {
        int          cyc;
        logic [15:0] d;
        logic [1:0]  be;
    } oe_ev_t;

    cmd_ev_t cmd_q[$];
    rd_ev_t  rd_q[$];
    oe_ev_t  oe_q[$];

    task automatic check(input string name, input bit ok, input string got, input string exp);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: got %s, expected %s", name, got, exp);
        end
    endtask

    task automatic push_cmd(input int c, input logic [3:0] k, input logic [21:0] a,
                            input logic [1:0] b, input bit chk);
        cmd_ev_t e;
        e.cyc = c; e.cmd = k; e.addr = a; e.be = b; e.chk = chk;
        cmd_q.push_back(e);
    endtask

    task automatic push_rd(input int c, input logic [15:0] d);
        rd_ev_t e;
        e.cyc = c; e.d = d;
        rd_q.push_back(e);
    endtask

    task automatic push_oe(input int c, input logic [15:0] d, input logic [1:0] b);
        oe_ev_t e;
        e.cyc = c; e.d = d; e.be = b;
        oe_q.push_back(e);
    endtask

    // 100 NOPs, PALL, 2 NOPs, REF, 7 NOPs, REF, 7 NOPs, MRS, 2 NOPs, init_done.
    task automatic push_init(input int base);
        push_cmd(base + 101, C_PALL, '0, '0, 1'b0);
        push_cmd(base + 104, C_REF,  '0, '0, 1'b0);
        push_cmd(base + 112, C_REF,  '0, '0, 1'b0);
        push_cmd(base + 120, C_MRS,  '0, '0, 1'b0);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_init(input int exp_cyc);
        for (int i = 0; i < 400 && !init_done; i++) @(negedge clk);
        check("init_done_rise", init_done && cyc == exp_cyc,
              $sformatf("init_done=%0b at cyc %0d", init_done, cyc),
              $sformatf("init_done=1 at cyc %0d", exp_cyc));
        check("ready_after_init", req_ready == 1'b1,
              $sformatf("%0b", req_ready), "1");
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        cmd_ev_t ce;
        rd_ev_t  re;
        oe_ev_t  oe;
        if (rst_n) begin
            if (command != C_NOP && command != C_DESL) begin
                if (cmd_q.size() == 0) begin
                    check("unexpected_cmd", 1'b0, $sformatf("cmd=%b at cyc %0d", command, cyc), "no command");
                end else begin
                    ce = cmd_q.pop_front();
                    check("cmd_event",
                          command == ce.cmd && cyc == ce.cyc &&
                          (!ce.chk || (addr_out == ce.addr && be_out == ce.be)) &&
                          (command != C_MRS || mrs == 12'h020),
                          $sformatf("cmd=%b cyc=%0d addr=%h be=%b mrs=%h", command, cyc, addr_out, be_out, mrs),
                          $sformatf("cmd=%b cyc=%0d addr=%h be=%b mrs=020", ce.cmd, ce.cyc, ce.addr, ce.be));
                end
            end
            if (rd_valid) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_rd_valid", 1'b0, $sformatf("rd_valid at cyc %0d", cyc), "none");
                end else begin
                    re = rd_q.pop_front();
                    check("rd_event", rd_data == re.d && cyc == re.cyc,
                          $sformatf("rd_data=%h cyc=%0d", rd_data, cyc),
                          $sformatf("rd_data=%h cyc=%0d", re.d, re.cyc));
                end
            end
            if (dq_oe) begin
                if (oe_q.size() == 0) begin
                    check("unexpected_dq_oe", 1'b0, $sformatf("dq_oe at cyc %0d", cyc), "none");
                end else begin
                    oe = oe_q.pop_front();
                    check("oe_event", dq_out == oe.d && be_out == oe.be && cyc == oe.cyc,
                          $sformatf("dq_out=%h be=%b cyc=%0d", dq_out, be_out, cyc),
                          $sformatf("dq_out=%h be=%b cyc=%0d", oe.d, oe.be, oe.cyc));
                end
            end
        end
    end

    int base;
    int base2;
    int d0;
    int p0;

    initial begin
        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_command",   command == C_DESL,  $sformatf("%b", command), "0000");
        check("rst_addr_out",  addr_out == 22'h0,  $sformatf("%h", addr_out), "000000");
        check("rst_be_out",    be_out == 2'b11,    $sformatf("%b", be_out), "11");
        check("rst_dq",        dq_out == 16'h0 && dq_oe == 1'b0,
              $sformatf("dq_out=%h dq_oe=%b", dq_out, dq_oe), "dq_out=0000 dq_oe=0");
        check("rst_rd",        rd_data == 16'h0 && rd_valid == 1'b0,
              $sformatf("rd_data=%h rd_valid=%b", rd_data, rd_valid), "rd_data=0000 rd_valid=0");
        check("rst_ready_done", req_ready == 1'b0 && init_done == 1'b0,
              $sformatf("ready=%b done=%b", req_ready, init_done), "ready=0 done=0");
        check("mrs_const",     mrs == 12'h020,     $sformatf("%h", mrs), "020");

        // Release reset, run init.
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = cyc;
        push_init(base);
        wait_init(base + 123);
        d0 = base + 123;

        // Read, then a write queued behind it while the read is in flight.
        wait_cyc(d0);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 22'h3ABC12; req_be = 2'b00; dq_in = 16'hBEEF;
        push_cmd(d0 + 1, C_ACT,   22'h3ABC12, 2'b00, 1'b1);
        push_cmd(d0 + 3, C_READA, 22'h3ABC12, 2'b00, 1'b1);
        push_rd(d0 + 6, 16'hBEEF);
        wait_cyc(d0 + 1);
        check("busy_ready_low", req_ready == 1'b0, $sformatf("%b", req_ready), "0");
        req_we = 1'b1; req_addr = 22'h0A5A5A; req_be = 2'b01; req_wdata = 16'h1234;
        push_cmd(d0 + 7, C_ACT,   22'h0A5A5A, 2'b01, 1'b1);
        push_cmd(d0 + 9, C_WRITA, 22'h0A5A5A, 2'b01, 1'b1);
        push_oe(d0 + 9, 16'h1234, 2'b01);
        wait_cyc(d0 + 7);
        req_valid = 1'b0;
        wait_cyc(d0 + 12);
        check("wr_recovery_ready_low", req_ready == 1'b0, $sformatf("%b", req_ready), "0");
        wait_cyc(d0 + 13);
        check("wr_ready_back", req_ready == 1'b1, $sformatf("%b", req_ready), "1");

        // Refresh expiry at init_done + 780; request raised on that very cycle.
        p0 = d0 + 780;
        wait_cyc(p0 - 1);
        check("ready_before_ref", req_ready == 1'b1, $sformatf("%b", req_ready), "1");
        wait_cyc(p0);
        check("ref_pending_ready_low", req_ready == 1'b0, $sformatf("%b", req_ready), "0");
        req_valid = 1'b1; req_we = 1'b0; req_addr = 22'h155AA3; req_be = 2'b10; dq_in = 16'hC0DE;
        push_cmd(p0 + 1,  C_REF,   '0, '0, 1'b0);
        push_cmd(p0 + 9,  C_ACT,   22'h155AA3, 2'b10, 1'b1);
        push_cmd(p0 + 11, C_READA, 22'h155AA3, 2'b10, 1'b1);
        push_rd(p0 + 14, 16'hC0DE);
        wait_cyc(p0 + 9);
        req_valid = 1'b0;

        // Read abandoned by reset during READ_WAIT.
        wait_cyc(p0 + 14);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 22'h2FEDCB; req_be = 2'b11;
        push_cmd(p0 + 15, C_ACT,   22'h2FEDCB, 2'b11, 1'b1);
        push_cmd(p0 + 17, C_READA, 22'h2FEDCB, 2'b11, 1'b1);
        wait_cyc(p0 + 15);
        req_valid = 1'b0;
        dq_in = 16'h5A5A;
        wait_cyc(p0 + 18);
        rst_n = 1'b0;
        #1;
        check("midread_rst_desl", command == C_DESL, $sformatf("%b", command), "0000");
        check("midread_rst_outs",
              rd_valid == 1'b0 && init_done == 1'b0 && req_ready == 1'b0 && be_out == 2'b11 && addr_out == 22'h0,
              $sformatf("rdv=%b done=%b rdy=%b be=%b addr=%h", rd_valid, init_done, req_ready, be_out, addr_out),
              "rdv=0 done=0 rdy=0 be=11 addr=000000");
        wait_cyc(p0 + 21);
        check("rst_no_rd_valid", rd_valid == 1'b0, $sformatf("%b", rd_valid), "0");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base2 = cyc;
        push_init(base2);
        wait_init(base2 + 123);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", cmd_q.size() == 0 && rd_q.size() == 0 && oe_q.size() == 0,
              $sformatf("cmd=%0d rd=%0d oe=%0d left", cmd_q.size(), rd_q.size(), oe_q.size()),
              "all empty");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_cmd_sequencer.md
SDRAM_CMD_SEQUENCER -- requirements
Module: sdram_cmd_sequencer

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- INIT_WAIT, 100, power-up NOP cycles
- T_RP, 2, precharge cycles
- T_RFC, 7, refresh cycles
- T_RCD, 2, ACT-to-column cycles
- CAS_LAT, 2, read latency
- T_WR, 2, write recovery cycles
- REF_INTERVAL, 780, cycles between refreshes
- MRS_VALUE, 12'h020, mode word for CL2, burst length 1
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- req_valid / req_ready, in / out, 1 / 1, request handshake
- req_we, in, 1, 1 = write, 0 = read
- req_addr, in, 22, {bank[21:20], row[19:8], col[7:0]}
- req_be, in, 2, byte mask passed to dqm
- req_wdata, in, 16, write data
- command, out, 4, command code
- mrs, out, 12, mode word
- addr_out, out, 22, latched address
- be_out, out, 2, latched mask
- dq_in / dq_out / dq_oe, in / out / out, 16 / 16 / 1, data bus
- rd_data / rd_valid, out / out, 16 / 1, read return
- init_done, out, 1, initialisation complete

Function
REQ-003 command SHALL use these codes: DESL 0000, NOP 0001, MRS 0010, ACT 0011, READA 0101, WRITA 0111, PALL 1001, REF 1011.
REQ-004 command SHALL be registered and SHALL show each non-NOP code for exactly one cycle, with NOP between codes; mrs SHALL be constant MRS_VALUE.
REQ-005 The state machine SHALL have states INIT_WAIT, INIT_PALL, INIT_REF1, INIT_REF2, INIT_MRS, IDLE, REFRESH, ACTIVATE, RW, READ_WAIT, WRITE_WAIT, driven by one shared down-counter.
REQ-006 Initialisation SHALL run as follows:
- INIT_WAIT_CYCLES NOP cycles (INIT_WAIT),
- PALL, then T_RP NOPs,
- REF, then T_RFC NOPs,
- REF, then T_RFC NOPs,
- MRS, then 2 NOPs,
- then IDLE, with init_done set and held high until reset.
REQ-007 req_ready SHALL be 1 only when the state is IDLE, init_done=1 and ref_pending=0.
REQ-008 On req_valid&req_ready the block SHALL latch req_addr, req_be, req_we and req_wdata into addr_out, be_out and internal registers, and SHALL issue ACT on the next cycle.
REQ-009 READA/WRITA SHALL issue exactly T_RCD cycles after ACT, using the latched address.
REQ-010 Read path:
- dq_in SHALL be sampled at the edge CAS_LAT cycles after the READA cycle.
- rd_data SHALL take the sampled value and rd_valid SHALL pulse 1 cycle on the next cycle.
- IDLE SHALL be re-entered on that same cycle.
REQ-011 Write path:
- dq_oe=1 and dq_out=latched wdata SHALL hold during the WRITA cycle only.
- IDLE SHALL be re-entered T_WR+T_RP cycles after WRITA.
REQ-012 The refresh counter SHALL start at REF_INTERVAL-1 when init_done rises, decrement every cycle, and on reaching 0 set ref_pending and reload.
REQ-013 In IDLE, ref_pending SHALL take priority over req_valid: REF issues, T_RFC NOPs follow, then IDLE.
REQ-014 ref_pending SHALL clear on the REF cycle; if the counter expires on that same cycle, ref_pending SHALL stay set.
REQ-015 A request arriving during refresh or an access SHALL be held off by req_ready=0 and SHALL NOT be dropped; the requester holds req_valid.
REQ-016 Width rules:
- the wait counter SHALL be wide enough for max(INIT_WAIT, REF_INTERVAL);
- no counter SHALL wrap below 0.

Reset
REQ-017 While rst_n=0 the outputs SHALL be: command=DESL, addr_out=0, be_out=2'b11, dq_out=0, dq_oe=0, rd_data=0, rd_valid=0, req_ready=0, init_done=0, ref_pending=0, state=INIT_WAIT.
REQ-018 On rst_n rising, initialisation SHALL restart from INIT_WAIT, and any in-flight access SHALL be abandoned with no rd_valid.

Verification
REQ-019 Release reset -> 100 NOPs, PALL, 2 NOPs, REF, 7 NOPs, REF, 7 NOPs, MRS (mrs=12'h020), 2 NOPs, then init_done=1 and req_ready=1.
REQ-020 Read addr=22'h3ABC12, be=00, dq_in=16'hBEEF -> ACT with addr_out=22'h3ABC12, READA 2 cycles later, rd_valid pulse with rd_data=16'hBEEF 3 cycles after READA.
REQ-021 Write wdata=16'h1234, be=01 -> dq_oe high only in the WRITA cycle with dq_out=16'h1234 and be_out=01, req_ready back to 1 after 4 cycles.
REQ-022 Hold req_valid on the cycle ref_pending sets -> REF is issued first, then after 7 NOPs the ACT for the held request.
REQ-023 Assert rst_n=0 during READ_WAIT -> command=DESL immediately, no rd_valid, and the full init sequence reruns.
